// File: rtl/rv_pipe_pkg.sv
// ----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared constants for the rv32i pipeline hazard logic.
//   REG_ADDR_W : architectural register address width
//   SEL_*      : forward-select encoding (0 = regfile, k = tap k-1)
//   sel_width  : width of one forward-select field for a given tap count
// ----------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int SEL_RF   = 0;
    localparam int SEL_TAP0 = 1;
    localparam int SEL_TAP1 = 2;

    // One code per tap plus the regfile code; never narrower than one bit.
    function automatic int sel_width(input int nfwd);
        return (nfwd < 1) ? 1 : $clog2(nfwd + 1);
    endfunction

endpackage : rv_pipe_pkg

// File: rtl/fwd_match_prio.sv
// ----------------------------------------------------------------------------
// fwd_match_prio
// Priority matcher for one source operand against all forwarding taps.
// The lowest-index (youngest) tap that writes the operand's register wins.
// Ports:
//   active    : operand is valid, read, and not x0
//   rs        : operand register address
//   fwd_rd    : destination register of each tap, tap k at [5k+4:5k]
//   fwd_we    : tap writes a register
//   fwd_ready : tap's result value is available
//   sel       : forward select (SEL_RF when no tap matches)
//   hit       : some tap matches
//   tap_ready : ready flag of the winning tap (1 when no hit)
// ----------------------------------------------------------------------------
module fwd_match_prio
    import rv_pipe_pkg::*;
#(
    parameter int NFWD = 2,
    parameter int SELW = 2
) (
    input  logic                         active,
    input  logic [REG_ADDR_W-1:0]        rs,
    input  logic [NFWD*REG_ADDR_W-1:0]   fwd_rd,
    input  logic [NFWD-1:0]              fwd_we,
    input  logic [NFWD-1:0]              fwd_ready,
    output logic [SELW-1:0]              sel,
    output logic                         hit,
    output logic                         tap_ready
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        sel       = SELW'(SEL_RF);
        hit       = 1'b0;
        tap_ready = 1'b1;
        // Walk from the oldest tap down so the youngest match is written last.
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (active && fwd_we[k] && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
                sel       = SELW'(SEL_TAP0 + k);
                hit       = 1'b1;
                tap_ready = fwd_ready[k];
            end
        end
    end

endmodule : fwd_match_prio

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Forwarding-select and stall generation for the decode stage, plus a
// per-register busy scoreboard for outstanding long-latency writebacks.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   id_valid/id_rs/id_rs_used : decoding instruction and its source operands
//   id_rd/id_long/id_fire     : destination, long-latency flag, advance to EX
//   fwd_rd/fwd_we/fwd_ready   : per-tap destination, write enable, value ready
//   cpl_valid/cpl_rd          : long-latency completion written to regfile
//   fwd_sel                   : per-operand forward select, SELW bits each
//   stall                     : hold ID/IF and insert an EX bubble
//   sb_full                   : outstanding count at MAX_OUT (registered)
//   busy_vec                  : registered per-register busy bits
//   stall_cnt                 : saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter  int NRD     = 2,
    parameter  int NFWD    = 2,
    parameter  int NREG    = 32,
    parameter  int MAX_OUT = 4,
    parameter  int CNT_W   = 32,
    localparam int SELW    = sel_width(NFWD)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NRD*REG_ADDR_W-1:0]   id_rs,
    input  logic [NRD-1:0]              id_rs_used,
    input  logic [REG_ADDR_W-1:0]       id_rd,
    input  logic                        id_long,
    input  logic                        id_fire,
    input  logic [NFWD*REG_ADDR_W-1:0]  fwd_rd,
    input  logic [NFWD-1:0]             fwd_we,
    input  logic [NFWD-1:0]             fwd_ready,
    input  logic                        cpl_valid,
    input  logic [REG_ADDR_W-1:0]       cpl_rd,
    output logic [NRD*SELW-1:0]         fwd_sel,
    output logic                        stall,
    output logic                        sb_full,
    output logic [NREG-1:0]             busy_vec,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic             sb_full_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [NRD-1:0]   op_hazard;
    logic             structural, waw;
    logic             issue, retire;

    // ------------------------------------------------------------------
    // Per-operand forwarding and data hazards
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_op
        logic [REG_ADDR_W-1:0] rs;
        logic                  active;
        logic                  hit;
        logic                  tap_ready;

        assign rs     = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
        assign active = id_valid & id_rs_used[i] & (rs != '0);

        fwd_match_prio #(
            .NFWD (NFWD),
            .SELW (SELW)
        ) u_match (
            .active    (active),
            .rs        (rs),
            .fwd_rd    (fwd_rd),
            .fwd_we    (fwd_we),
            .fwd_ready (fwd_ready),
            .sel       (fwd_sel[i*SELW +: SELW]),
            .hit       (hit),
            .tap_ready (tap_ready)
        );

        // A matching tap decides alone; otherwise a pending writeback blocks
        // unless it lands in the regfile this very cycle (write-through).
        assign op_hazard[i] = hit ? ~tap_ready
                                  : (active & busy_q[rs] & ~(cpl_valid & (cpl_rd == rs)));
    end

    // A completion this cycle frees a slot, so a full scoreboard can still issue.
    assign structural = id_long & (outstanding_q == OUT_W'(MAX_OUT)) & ~cpl_valid;
    // Only one pending op per register: a second long writer waits.
    assign waw        = id_long & (id_rd != '0) & busy_q[id_rd];
    assign stall      = id_valid & (|op_hazard | structural | waw);

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    assign issue  = id_fire & id_long & (id_rd != '0);
    assign retire = cpl_valid & (cpl_rd != '0);

    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        // Clear before set so a same-register issue leaves the new op pending.
        if (retire) busy_d[cpl_rd] = 1'b0;
        if (issue)  busy_d[id_rd]  = 1'b1;
        case ({issue, retire})
            2'b10:   if (outstanding_q != OUT_W'(MAX_OUT)) outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   if (outstanding_q != '0)              outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state, so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the busy bits are reset along with the counters; a reset
            // mid-run must forget every pending writeback at once.
            busy_q        <= '0;
            outstanding_q <= '0;
            sb_full_q     <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            sb_full_q     <= (outstanding_d == OUT_W'(MAX_OUT));
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign busy_vec  = busy_q;
    assign sb_full   = sb_full_q;
    assign stall_cnt = stall_cnt_q;

    // A completion with nothing outstanding means the core lost track of an op.
    cpl_underflow: assert property (@(posedge clk) disable iff (!reset)
                                    !(retire && (outstanding_q == '0)));

endmodule : hazard_scoreboard
